grand_adder_pipe: RTL and testbench

Pipelined, parametrised successor of the FMA grand-adder stage: it takes the product carry-save pair and the aligned high part of the addend and forms the magnitude-form sum, result sign, sign-flip flag and minus-sticky bit. It sits between the multiplier CSA tree and the LZA/normaliser. Timing is split over two register stages with a valid/ready handshake, so downstream stalls do not lose operations. Exponent/mantissa widths are parameters, so the same block serves binary16, binary32 and binary64 MAC instances.

---
 rtl/grand_adder_pipe_pkg.sv | 35 +++
 rtl/grand_adder_pipe_if.sv | 41 ++++
 rtl/grand_adder_stage_reg.sv | 47 ++++
 rtl/grand_adder_pipe.sv | 129 ++++++++++++
 tb/tb_grand_adder_pipe.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/grand_adder_pipe_pkg.sv
// Shared definitions for the FMA grand-adder pipeline: derived datapath widths
// and the control bundle carried through the first register stage.
package grand_adder_pipe_pkg;

    // Low part of the product carry-save pair.
    function automatic int unsigned low_width(input int unsigned mant);
        return 2 * mant + 2;
    endfunction

    // Aligned addend high part.
    function automatic int unsigned high_width(input int unsigned mant);
        return mant + 4;
    endfunction

    // Magnitude result; one bit narrower than the full high:low value.
    function automatic int unsigned res_width(input int unsigned mant);
        return 3 * mant + 5;
    endfunction

    typedef struct packed {
        logic sub;
        logic exp_mv_sign;
        logic mv_halt;
        logic sign_aligned;
        logic bc_special;
    } ga_ctrl_t;

    localparam int unsigned CtrlW = $bits(ga_ctrl_t);

    // S1 payload width: lo, inverted lo, low carry, addend high part, controls.
    function automatic int unsigned s1_width(input int unsigned mant);
        return 2 * low_width(mant) + 1 + high_width(mant) + CtrlW;
    endfunction

endpackage

// File: rtl/grand_adder_pipe_if.sv
// Operand/result bundle of the grand-adder pipeline with valid/ready handshakes.
interface grand_adder_pipe_if
    import grand_adder_pipe_pkg::*;
#(
    parameter int unsigned PARM_MANT = 23
);
    localparam int unsigned LoW  = low_width(PARM_MANT);
    localparam int unsigned HiW  = high_width(PARM_MANT);
    localparam int unsigned ResW = res_width(PARM_MANT);

    logic            in_valid_i;
    logic            in_ready_o;
    logic [LoW-1:0]  csa_sum_i;
    logic [LoW-1:0]  csa_carry_i;
    logic            sub_i;
    logic [HiW-1:0]  a_high_i;
    logic            exp_mv_sign_i;
    logic            mv_halt_i;
    logic            sign_aligned_i;
    logic            bc_special_i;

    logic            out_valid_o;
    logic            out_ready_i;
    logic [ResW-1:0] pos_sum_o;
    logic            adder_sign_o;
    logic            sign_flip_o;
    logic            minus_sticky_o;

    modport slave (
        input  in_valid_i, csa_sum_i, csa_carry_i, sub_i, a_high_i, exp_mv_sign_i,
               mv_halt_i, sign_aligned_i, bc_special_i, out_ready_i,
        output in_ready_o, out_valid_o, pos_sum_o, adder_sign_o, sign_flip_o, minus_sticky_o
    );

    modport master (
        output in_valid_i, csa_sum_i, csa_carry_i, sub_i, a_high_i, exp_mv_sign_i,
               mv_halt_i, sign_aligned_i, bc_special_i, out_ready_i,
        input  in_ready_o, out_valid_o, pos_sum_o, adder_sign_o, sign_flip_o, minus_sticky_o
    );

endinterface

// File: rtl/grand_adder_stage_reg.sv
// Generic valid/ready pipeline register with synchronous flush; no skid buffer,
// so in_ready_o is combinational from out_ready_i.
module grand_adder_stage_reg #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [Width-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [Width-1:0] out_data_o
);

    logic             valid_d, valid_q;
    logic [Width-1:0] data_d, data_q;

    assign in_ready_o  = ~valid_q | out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (in_ready_o) begin
            valid_d = in_valid_i;
            if (in_valid_i) begin
                data_d = in_data_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/grand_adder_pipe.sv
// Two-stage FMA grand adder: S1 adds the carry-save low part, S2 resolves the
// high part, takes the magnitude and selects the result per addend mode.
module grand_adder_pipe
    import grand_adder_pipe_pkg::*;
#(
    parameter int unsigned PARM_EXP  = 8,
    parameter int unsigned PARM_MANT = 23
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    grand_adder_pipe_if.slave bus_io
);

    localparam int unsigned LoW  = low_width(PARM_MANT);
    localparam int unsigned HiW  = high_width(PARM_MANT);
    localparam int unsigned ResW = res_width(PARM_MANT);

    typedef struct packed {
        logic [LoW-1:0] lo;
        logic [LoW-1:0] lo_inv;
        logic           c_lo;
        logic [HiW-1:0] a_high;
        ga_ctrl_t       ctrl;
    } s1_t;

    typedef struct packed {
        logic [ResW-1:0] pos_sum;
        logic            adder_sign;
        logic            sign_flip;
        logic            minus_sticky;
    } s2_t;

    // Exponent width only selects the format; keep it visible without datapath use.
    logic [31:0] unused_exp;
    assign unused_exp = PARM_EXP;

    s1_t          s1_d, s1_q;
    s2_t          s2_d, s2_q;
    logic         s1_valid, s2_ready;
    logic [LoW:0] low_sum;

    always_comb begin
        low_sum = {1'b0, bus_io.csa_sum_i} + {1'b0, bus_io.csa_carry_i}
                + {{LoW{1'b0}}, bus_io.sub_i};
        s1_d                   = '0;
        s1_d.lo                = low_sum[LoW-1:0];
        s1_d.lo_inv            = ~low_sum[LoW-1:0];
        s1_d.c_lo              = low_sum[LoW];
        s1_d.a_high            = bus_io.a_high_i;
        s1_d.ctrl.sub          = bus_io.sub_i;
        s1_d.ctrl.exp_mv_sign  = bus_io.exp_mv_sign_i;
        s1_d.ctrl.mv_halt      = bus_io.mv_halt_i;
        s1_d.ctrl.sign_aligned = bus_io.sign_aligned_i;
        s1_d.ctrl.bc_special   = bus_io.bc_special_i;
    end

    grand_adder_stage_reg #(
        .Width($bits(s1_t))
    ) u_s1 (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (flush_i),
        .in_valid_i (bus_io.in_valid_i),
        .in_ready_o (bus_io.in_ready_o),
        .in_data_i  (s1_d),
        .out_valid_o(s1_valid),
        .out_ready_i(s2_ready),
        .out_data_o (s1_q)
    );

    logic [HiW-1:0]  hi;
    logic [HiW-2:0]  neg_hi;
    logic [LoW-1:0]  neg_lo;
    logic            neg_carry;
    logic            neg;
    logic [ResW-1:0] v_pos, v_neg, mv_val, half_lsb;

    always_comb begin
        hi  = s1_q.a_high + {{(HiW - 1){1'b0}}, s1_q.c_lo};
        neg = hi[HiW-1];

        // Two's-complement negate reusing the stored inverted low sum.
        {neg_carry, neg_lo} = {1'b0, s1_q.lo_inv} + {{LoW{1'b0}}, 1'b1};
        neg_hi = ~hi[HiW-2:0] + {{(HiW - 2){1'b0}}, neg_carry};

        v_pos = {hi[HiW-2:0], s1_q.lo};
        v_neg = {neg_hi, neg_lo};

        half_lsb          = '0;
        half_lsb[LoW-1]   = s1_q.ctrl.sub & ~s1_q.ctrl.bc_special;
        mv_val            = {s1_q.a_high[HiW-2:0], {LoW{1'b0}}} - half_lsb;

        s2_d              = '0;
        s2_d.sign_flip    = neg;
        s2_d.minus_sticky = s1_q.ctrl.exp_mv_sign & ~s1_q.ctrl.bc_special;
        s2_d.adder_sign   = s1_q.ctrl.exp_mv_sign ? s1_q.ctrl.sign_aligned
                                                  : (neg ^ s1_q.ctrl.sign_aligned);
        if (s1_q.ctrl.mv_halt) begin
            s2_d.pos_sum = {{(ResW - LoW){1'b0}}, s1_q.lo};
        end else if (s1_q.ctrl.exp_mv_sign) begin
            s2_d.pos_sum = mv_val;
        end else if (neg) begin
            s2_d.pos_sum = v_neg;
        end else begin
            s2_d.pos_sum = v_pos;
        end
    end

    grand_adder_stage_reg #(
        .Width($bits(s2_t))
    ) u_s2 (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (flush_i),
        .in_valid_i (s1_valid),
        .in_ready_o (s2_ready),
        .in_data_i  (s2_d),
        .out_valid_o(bus_io.out_valid_o),
        .out_ready_i(bus_io.out_ready_i),
        .out_data_o (s2_q)
    );

    assign bus_io.pos_sum_o      = s2_q.pos_sum;
    assign bus_io.adder_sign_o   = s2_q.adder_sign;
    assign bus_io.sign_flip_o    = s2_q.sign_flip;
    assign bus_io.minus_sticky_o = s2_q.minus_sticky;

endmodule

// File: tb/tb_grand_adder_pipe.sv
// Scoreboard bench for grand_adder_pipe at M=23: directed corner cases,
// backpressure, flush, reset under stall and a randomized stream.
module tb_grand_adder_pipe;

    localparam int unsigned L = 48;
    localparam int unsigned H = 27;
    localparam int unsigned W = 74;

    typedef struct packed {
        logic [L-1:0] sum;
        logic [L-1:0] carry;
        logic         sub;
        logic [H-1:0] a_high;
        logic         emv;
        logic         halt;
        logic         sa;
        logic         bc;
    } op_t;

    typedef struct packed {
        logic [W-1:0] pos;
        logic         adder_sign;
        logic         sign_flip;
        logic         minus_sticky;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic rdy_fixed = 1'b1;
    logic rand_rdy = 1'b0;
    logic use_fixed = 1'b0;
    exp_t fixed_exp;
    op_t  cur_op;

    int   total = 0;
    int   bad = 0;
    int   acc_cnt = 0;
    int   out_cnt = 0;
    exp_t sb[$];

    grand_adder_pipe_if #(.PARM_MANT(23)) bus ();

    grand_adder_pipe #(
        .PARM_EXP (8),
        .PARM_MANT(23)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .flush_i(flush),
        .bus_io(bus)
    );

    assign bus.in_valid_i     = in_valid;
    assign bus.csa_sum_i      = cur_op.sum;
    assign bus.csa_carry_i    = cur_op.carry;
    assign bus.sub_i          = cur_op.sub;
    assign bus.a_high_i       = cur_op.a_high;
    assign bus.exp_mv_sign_i  = cur_op.emv;
    assign bus.mv_halt_i      = cur_op.halt;
    assign bus.sign_aligned_i = cur_op.sa;
    assign bus.bc_special_i   = cur_op.bc;
    assign bus.out_ready_i    = out_ready;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_fixed;
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: got=timeout want=progress", name);
    endtask

    // Reference: value arithmetic on wide unsigned integers.
    function automatic exp_t model(input op_t op);
        exp_t         e;
        logic [127:0] lo_full, lo, hi, v, mag, mv;
        logic         neg;
        lo_full = 128'(op.sum) + 128'(op.carry) + 128'(op.sub);
        lo      = lo_full % (128'd1 << L);
        hi      = (128'(op.a_high) + (lo_full >> L)) % (128'd1 << H);
        v       = hi * (128'd1 << L) + lo;
        neg     = hi >= (128'd1 << (H - 1));
        mag     = neg ? (128'd1 << (H + L)) - v : v;
        mv      = (128'(op.a_high) % (128'd1 << (H - 1))) * (128'd1 << L)
                - ((op.sub && !op.bc) ? (128'd1 << (L - 1)) : 128'd0);
        if (op.halt)     e.pos = W'(lo);
        else if (op.emv) e.pos = W'(mv % (128'd1 << W));
        else             e.pos = W'(mag % (128'd1 << W));
        e.sign_flip    = neg;
        e.adder_sign   = op.emv ? op.sa : (neg ^ op.sa);
        e.minus_sticky = op.emv && !op.bc;
        return e;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        o.sum    = 48'({$urandom(), $urandom()});
        o.carry  = 48'({$urandom(), $urandom()});
        if ($urandom_range(0, 7) == 0) o.sum = '1;
        o.sub    = 1'($urandom_range(0, 1));
        o.a_high = 27'($urandom());
        if ($urandom_range(0, 3) == 0) o.a_high = '1;
        o.emv    = ($urandom_range(0, 3) == 0);
        o.halt   = ($urandom_range(0, 7) == 0);
        o.sa     = 1'($urandom_range(0, 1));
        o.bc     = ($urandom_range(0, 3) == 0);
        return o;
    endfunction

    function automatic op_t mk_op(input logic [L-1:0] s, input logic [L-1:0] c, input logic sub,
                                  input logic [H-1:0] ah, input logic emv, input logic sa,
                                  input logic bc);
        op_t o;
        o.sum = s; o.carry = c; o.sub = sub; o.a_high = ah;
        o.emv = emv; o.halt = 1'b0; o.sa = sa; o.bc = bc;
        return o;
    endfunction

    // Stimulus side of the scoreboard: record what each accepted op must produce.
    always @(negedge clk) begin
        if (!rst_n || flush) begin
            sb.delete();
        end else if (in_valid && bus.in_ready_o) begin
            sb.push_back(use_fixed ? fixed_exp : model(cur_op));
            acc_cnt++;
        end
    end

    exp_t got, held, want;
    logic held_v = 1'b0;

    always @(negedge clk) begin
        got.pos          = bus.pos_sum_o;
        got.adder_sign   = bus.adder_sign_o;
        got.sign_flip    = bus.sign_flip_o;
        got.minus_sticky = bus.minus_sticky_o;
        if (!rst_n) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                check("stall_valid_hold", 128'(bus.out_valid_o), 128'(1));
                check("stall_data_hold", 128'(got), 128'(held));
            end
            if (bus.out_valid_o && bus.out_ready_i) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 128'(got), 128'(0));
                    bad += (got == '0) ? 1 : 0;
                end else begin
                    want = sb.pop_front();
                    check("result", 128'(got), 128'(want));
                end
                out_cnt++;
                held_v = 1'b0;
            end else begin
                held_v = bus.out_valid_o && !flush;
                held   = got;
            end
        end
    end

    task automatic send(input op_t op);
        int n;
        n = 0;
        cur_op   = op;
        in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) fail_now("send_timeout");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_fixed(input op_t op, input exp_t e);
        use_fixed = 1'b1;
        fixed_exp = e;
        send(op);
        use_fixed = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        @(negedge clk);
        while ((sb.size() != 0 || bus.out_valid_o) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 128'(sb.size()), 128'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0, out0;
        cur_op   = rand_op();
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 128'(bus.out_valid_o), 128'(0));
        check("rst_pos_sum", 128'(bus.pos_sum_o), 128'(0));
        check("rst_flags", 128'({bus.adder_sign_o, bus.sign_flip_o, bus.minus_sticky_o}), 128'(0));
        @(posedge clk); #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 128'(bus.in_ready_o), 128'(1));

        @(posedge clk); #1;
        send_fixed(mk_op(48'd5, 48'd3, 1'b0, 27'd0, 1'b0, 1'b0, 1'b0),
                   '{pos: 74'd8, adder_sign: 1'b0, sign_flip: 1'b0, minus_sticky: 1'b0});
        send_fixed(mk_op(48'd3, 48'd0, 1'b0, 27'h7FF_FFFF, 1'b0, 1'b0, 1'b0),
                   '{pos: 74'hFFFF_FFFF_FFFD, adder_sign: 1'b1, sign_flip: 1'b1,
                     minus_sticky: 1'b0});
        send_fixed(mk_op(48'd0, 48'd0, 1'b1, 27'd5, 1'b1, 1'b1, 1'b0),
                   '{pos: 74'h4_8000_0000_0000, adder_sign: 1'b1, sign_flip: 1'b0,
                     minus_sticky: 1'b1});
        send_fixed(mk_op(48'd0, 48'd0, 1'b1, 27'd5, 1'b1, 1'b0, 1'b1),
                   '{pos: 74'h5_0000_0000_0000, adder_sign: 1'b0, sign_flip: 1'b0,
                     minus_sticky: 1'b0});
        wait_drain();

        // Backpressure: only the two stages can hold work.
        @(posedge clk); #1;
        rdy_fixed = 1'b0;
        acc0 = acc_cnt;
        out0 = out_cnt;
        for (int i = 0; i < 4; i++) begin
            cur_op   = rand_op();
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_accepted", 128'(acc_cnt - acc0), 128'(2));
        check("bp_in_ready", 128'(bus.in_ready_o), 128'(0));
        rdy_fixed = 1'b1;
        wait_drain();
        check("bp_drained", 128'(out_cnt - out0), 128'(2));

        // Flush with both stages full; the op offered alongside is dropped.
        @(posedge clk); #1;
        rdy_fixed = 1'b0;
        send(rand_op());
        send(rand_op());
        flush    = 1'b1;
        cur_op   = rand_op();
        in_valid = 1'b1;
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_out_valid", 128'(bus.out_valid_o), 128'(0));
        check("flush_in_ready", 128'(bus.in_ready_o), 128'(1));
        @(posedge clk); #1;
        rdy_fixed = 1'b1;
        send_fixed(mk_op(48'd100, 48'd23, 1'b0, 27'd0, 1'b0, 1'b1, 1'b0),
                   '{pos: 74'd123, adder_sign: 1'b1, sign_flip: 1'b0, minus_sticky: 1'b0});
        wait_drain();

        // Reset during a stall discards held data without an output pulse.
        @(posedge clk); #1;
        rdy_fixed = 1'b0;
        send(rand_op());
        send(rand_op());
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_stall_valid", 128'(bus.out_valid_o), 128'(0));
        check("rst_stall_pos", 128'(bus.pos_sum_o), 128'(0));
        out0 = out_cnt;
        rdy_fixed = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_stall_no_pulse", 128'(out_cnt - out0), 128'(0));

        // Randomized stream with random output stalls.
        @(posedge clk); #1;
        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send(rand_op());
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
        rand_rdy = 1'b0;
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
